// File: rtl/fsgnjx_s.sv
// FSGNJX.S sign-injection for the FPU execute stage: y = x1 with sign x1[31]^x2_sign.
// Define FSGNJX_S_COMB_EN for a zero-latency combinational variant; default is 1-cycle registered.
module fsgnjx_s (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic        x2_sign,
    input  logic        in_valid,
    output logic [31:0] y,
    output logic        out_valid
);

    // Pure bit manipulation: NaN payloads, quiet bits and zero signs all pass through.
    function automatic logic [31:0] sign_inject_x(input logic [31:0] a, input logic s);
        return {a[31] ^ s, a[30:0]};
    endfunction

`ifdef FSGNJX_S_COMB_EN

    logic unused_clk_rst;
    assign unused_clk_rst = clk & rstn;

    assign y         = sign_inject_x(x1, x2_sign);
    assign out_valid = in_valid;

`else

    logic [31:0] y_d, y_q;
    logic        out_valid_d, out_valid_q;

    // Holding on !in_valid keeps undriven operands from reaching y.
    always_comb begin
        y_d         = y_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            y_d = sign_inject_x(x1, x2_sign);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            y_q         <= 32'h0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

`endif

endmodule

// File: tb/tb_fsgnjx_s.sv
// Randomized self-checking bench for fsgnjx_s (default registered build).
// A spec-level model tracks the expected y/out_valid after every clock edge.
module tb_fsgnjx_s;

    logic        clk;
    logic        rstn;
    logic [31:0] x1;
    logic        x2_sign;
    logic        in_valid;
    logic [31:0] y;
    logic        out_valid;

    int n_checks;
    int n_errors;

    logic [31:0] exp_y;
    logic        exp_vld;

    fsgnjx_s dut (
        .clk      (clk),
        .rstn     (rstn),
        .x1       (x1),
        .x2_sign  (x2_sign),
        .in_valid (in_valid),
        .y        (y),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result = |x1| carrying a negative sign exactly when the two operand signs differ.
    function automatic logic [31:0] ref_sgnjx(input logic [31:0] a, input logic s);
        logic [31:0] mag;
        logic        a_neg;
        mag   = a & 32'h7FFF_FFFF;
        a_neg = (a >= 32'h8000_0000);
        return (a_neg != s) ? (mag + 32'h8000_0000) : mag;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, want);
        end
    endtask

    // Drive one cycle, advance the model on the rising edge, then compare just after it.
    task automatic step(input logic r, input logic v, input logic [31:0] a, input logic s,
                        input string tag);
        @(negedge clk);
        rstn     = r;
        in_valid = v;
        x1       = a;
        x2_sign  = s;
        @(posedge clk);
        if (!r) begin
            exp_y   = 32'h0;
            exp_vld = 1'b0;
        end else begin
            exp_vld = v;
            if (v) exp_y = ref_sgnjx(a, s);
        end
        #1;
        check({tag, ".y"}, y, exp_y);
        check({tag, ".vld"}, {31'b0, out_valid}, {31'b0, exp_vld});
    endtask

    logic [31:0] dir_x1  [8];
    logic        dir_s   [8];
    logic [31:0] dir_exp [8];

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_y    = 32'h0;
        exp_vld  = 1'b0;
        rstn     = 1'b0;
        in_valid = 1'b0;
        x1       = 32'h0;
        x2_sign  = 1'b0;

        dir_x1[0] = 32'h3F800000; dir_s[0] = 1'b0; dir_exp[0] = 32'h3F800000;
        dir_x1[1] = 32'h3F800000; dir_s[1] = 1'b1; dir_exp[1] = 32'hBF800000;
        dir_x1[2] = 32'hC0490FDB; dir_s[2] = 1'b1; dir_exp[2] = 32'h40490FDB;
        dir_x1[3] = 32'hC0490FDB; dir_s[3] = 1'b0; dir_exp[3] = 32'hC0490FDB;
        dir_x1[4] = 32'h80000000; dir_s[4] = 1'b0; dir_exp[4] = 32'h80000000;
        dir_x1[5] = 32'h80000000; dir_s[5] = 1'b1; dir_exp[5] = 32'h00000000;
        dir_x1[6] = 32'h7FC00001; dir_s[6] = 1'b1; dir_exp[6] = 32'hFFC00001;
        dir_x1[7] = 32'hFF800000; dir_s[7] = 1'b1; dir_exp[7] = 32'h7F800000;

        // Reset asserted with valid traffic present: outputs must stay cleared.
        step(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, "reset0");
        step(1'b0, 1'b1, 32'h12345678, 1'b0, "reset1");

        // Directed vectors back-to-back, results one cycle after each input.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, dir_x1[i], dir_s[i], $sformatf("dir%0d", i));
            check($sformatf("dir%0d.const", i), y, dir_exp[i]);
        end

        // Idle cycles with garbage operands must hold the last result.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, $urandom, 1'($urandom), "hold");
            check("hold.const", y, 32'h7F800000);
        end

        // Mid-stream reset drops the in-flight result, then the stream resumes.
        step(1'b1, 1'b1, 32'h40000000, 1'b1, "pre_rst");
        step(1'b0, 1'b1, 32'h3F800000, 1'b1, "mid_rst");
        check("mid_rst.const", y, 32'h0);
        step(1'b1, 1'b1, 32'h00000001, 1'b1, "post_rst");
        check("post_rst.const", y, 32'h80000001);

        // Random traffic with occasional idles and resets.
        for (int i = 0; i < 3000; i++) begin
            logic r, v;
            r = ($urandom_range(0, 99) >= 3);
            v = ($urandom_range(0, 99) < 75);
            step(r, v, $urandom, 1'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
